button_conditioner: RTL and testbench

Front-end input stage for the whack-a-mole game. It takes the raw, asynchronous board pushbuttons (four mole buttons plus the start button) and synchronises and debounces each one. For every channel it produces a clean stable level, plus single-cycle press and release pulses. The game FSM consumes these outputs: levels for `start`, press pulses for the mole hits, so that one physical press scores at most once.

---
 rtl/button_conditioner.sv | 83 ++++++++
 tb/tb_button_conditioner.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton front end: two-flop synchroniser, per-channel debounce counter,
// and registered stable level plus one-cycle press/release pulses.
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic             r_any;
    logic [CNT_W-1:0] r_cnt [N_BTN];

    logic [N_BTN-1:0] w_accept;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_fall;

    // A channel flips on the edge where its input has differed for the full window
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if ((r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_LAST)) begin
                w_accept[i] = 1'b1;
            end else begin
                w_accept[i] = 1'b0;
            end
        end
    end

    assign w_rise = w_accept & ~r_level;
    assign w_fall = w_accept & r_level;

    // Synchroniser, debounce counters, stable level and edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_any     <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level   <= r_level ^ w_accept;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_any     <= |w_rise;
            for (int i = 0; i < N_BTN; i++) begin
                // Any sample agreeing with the level restarts the window
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign any_press   = r_any;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4: a sliding-window
// reference model predicts every cycle's outputs; a negedge monitor compares.
module tb_button_conditioner;

    localparam int N = 5;
    localparam int D = 4;
    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic         any_press;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press)
    );

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic         any;
    } exp_t;

    exp_t         sb_q [$];
    exp_t         mon_e;
    int           n_vec = 0;
    int           n_err = 0;

    logic [N-1:0] m_s1    = '0;
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_hist [$];   // synchronised samples, newest first

    // Level flips when the last D synchronised samples all disagree with it.
    function automatic void model_edge(input logic [N-1:0] raw, input logic r);
        exp_t         e;
        logic [N-1:0] acc;
        logic         ok;
        acc = '0;
        if (r) begin
            m_s1    = '0;
            m_level = '0;
            e       = '0;
            m_hist.push_front('0);
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                if (m_hist.size() >= D) begin
                    ok = 1'b1;
                    for (int k = 0; k < D; k++) begin
                        if (m_hist[k][ch] == m_level[ch]) ok = 1'b0;
                    end
                    acc[ch] = ok;
                end
            end
            e.level = m_level ^ acc;
            e.press = acc & ~m_level;
            e.rel   = acc & m_level;
            e.any   = |(acc & ~m_level);
            m_level = e.level;
            m_hist.push_front(m_s1);
            m_s1    = raw;
        end
        while (m_hist.size() > D) void'(m_hist.pop_back());
        sb_q.push_back(e);
    endfunction

    task automatic step(input logic [N-1:0] raw, input logic r);
        btn_raw = raw;
        rst     = r;
        @(posedge clk);
        model_edge(raw, r);
        @(negedge clk);
    endtask

    task automatic hold(input logic [N-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_vec++;
            if ({btn_level, btn_press, btn_release, any_press} !== mon_e) begin
                n_err++;
                $display("FAIL outputs vec %0d: level/press/release/any got %b/%b/%b/%b expected %b/%b/%b/%b",
                         n_vec, btn_level, btn_press, btn_release, any_press,
                         mon_e.level, mon_e.press, mon_e.rel, mon_e.any);
            end
        end
    end

    logic [N-1:0] rnd_raw;

    initial begin
        btn_raw = '0;
        rst     = 1'b1;
        // Reset with all buttons held, then release reset
        for (int i = 0; i < 3; i++) step(5'b11111, 1'b1);
        hold(5'b11111, 8);
        hold(5'b00000, 8);
        // Clean press and release on channel 0
        hold(5'b00001, 8);
        hold(5'b00000, 8);
        // Bounce train on channel 2
        step(5'b00100, 1'b0);
        step(5'b00000, 1'b0);
        step(5'b00100, 1'b0);
        step(5'b00000, 1'b0);
        hold(5'b00100, 8);
        hold(5'b00000, 8);
        // Short glitch on start channel
        hold(5'b10000, 3);
        hold(5'b00000, 8);
        // Simultaneous presses
        hold(5'b01011, 8);
        hold(5'b00000, 8);
        // Reset mid-count on channel 1
        hold(5'b00010, 2);
        step(5'b00010, 1'b1);
        hold(5'b00010, 8);
        hold(5'b00000, 8);
        // Random bouncing with occasional resets
        rnd_raw = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(7, 0) == 0) rnd_raw[ch] = ~rnd_raw[ch];
            end
            step(rnd_raw, ($urandom_range(199, 0) == 0) ? 1'b1 : 1'b0);
        end
        hold(5'b00000, 8);
        #1;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
